// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, line levels and parity helper.
// Line-level constants are also used by the receive path.
package uart_pkg;

    localparam int unsigned MAX_DATA_BITS = 9;
    localparam int unsigned BIT_CNT_W     = 4;

    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Unused upper bits must be zero so they do not disturb the XOR.
    function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data,
                                         input logic                     odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: Bit_Tick marks the last clock of each serial bit.
// Dropping En clears the count so every frame starts on a full bit period.
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic Clk,
    input  logic Rst,
    input  logic En,
    output logic Bit_Tick
);

    localparam int unsigned     CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt <= '0;
        end else if (!En || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign Bit_Tick = En && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a word over valid/ready and shifts out start,
// LSB-first data, optional parity and stop bit(s) with a one-cycle done pulse.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATA_BITS-1:0] Tx_Data,
    input  logic                 Tx_Valid,
    output logic                 Tx_Ready,
    input  logic                 BIST_Mode,
    output logic                 Tx_Serial,
    output logic                 Tx_Busy,
    output logic                 Tx_Done
);

    localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

    tx_state_t              state, state_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_next;
    logic                   parity_bit, parity_next;
    logic                   serial_next, busy_next, done_next;
    logic                   bit_tick;
    logic                   accept;

    assign Tx_Ready = (state == IDLE) && !BIST_Mode;
    assign accept   = Tx_Valid && Tx_Ready;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .Clk      (Clk),
        .Rst      (Rst),
        .En       (state != IDLE),
        .Bit_Tick (bit_tick)
    );

    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt;
        parity_next  = parity_bit;
        done_next    = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_next  = START;
                    shift_next  = Tx_Data;
                    parity_next = parity_calc(MAX_DATA_BITS'(Tx_Data), PARITY_ODD != 0);
                end
            end
            START: begin
                if (bit_tick) state_next = DATA;
            end
            DATA: begin
                // shift_reg[0] is always the bit currently on the line
                if (bit_tick) begin
                    if (bit_cnt == LAST_DATA) begin
                        bit_cnt_next = '0;
                        state_next   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_next = bit_cnt + BIT_CNT_W'(1);
                        shift_next   = shift_reg >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) state_next = STOP;
            end
            STOP: begin
                if (bit_tick) begin
                    if (bit_cnt == LAST_STOP) begin
                        bit_cnt_next = '0;
                        state_next   = IDLE;
                        done_next    = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt + BIT_CNT_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Line level is registered, so it is derived from where the FSM is going.
        case (state_next)
            START:   serial_next = START_LEVEL;
            DATA:    serial_next = shift_next[0];
            PARITY:  serial_next = parity_next;
            STOP:    serial_next = STOP_LEVEL;
            default: serial_next = LINE_IDLE;
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            parity_bit <= 1'b0;
            Tx_Serial  <= LINE_IDLE;
            Tx_Busy    <= 1'b0;
            Tx_Done    <= 1'b0;
        end else begin
            state      <= state_next;
            shift_reg  <= shift_next;
            bit_cnt    <= bit_cnt_next;
            parity_bit <= parity_next;
            Tx_Serial  <= serial_next;
            Tx_Busy    <= busy_next;
            Tx_Done    <= done_next;
        end
    end

endmodule
